// File: rtl/z80_bus_pkg.sv
// Shared types and widths for the tv80s bus memory/I/O responder.
package z80_bus_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, ACCESS} bus_state_t;
   localparam int Z80_ADDR_W = 16;
   localparam int Z80_DATA_W = 8;
endpackage

// File: rtl/z80_sp_ram.sv
// Single-clock RAM with one write port and two synchronous read ports.
module z80_sp_ram
   import z80_bus_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [Z80_DATA_W-1:0] wdata,
   input  logic                  re_a,
   input  logic [AW-1:0]         raddr_a,
   output logic [Z80_DATA_W-1:0] rdata_a,
   input  logic [AW-1:0]         raddr_b,
   output logic [Z80_DATA_W-1:0] rdata_b
);
   logic [Z80_DATA_W-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Only the read registers are reset; array contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         if (re_a)
            rdata_a <= mem[raddr_a];
         rdata_b <= mem[raddr_b];
      end
   end
endmodule

// File: rtl/z80_bus_mem.sv
// Memory and I/O responder for the tv80s bus: wait-state FSM, backdoor
// load/peek port and CPU write trace.
module z80_bus_mem
   import z80_bus_pkg::*;
#(
   parameter int         ADDR_W     = 16,
   parameter int         IO_ADDR_W  = 8,
   parameter int         MEM_WAIT   = 0,
   parameter int         IO_WAIT    = 1,
   parameter logic [7:0] IM2_VECTOR = 8'hFF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [Z80_ADDR_W-1:0] A,
   input  logic [Z80_DATA_W-1:0] dout,
   input  logic                  m1_n,
   input  logic                  mreq_n,
   input  logic                  iorq_n,
   input  logic                  rd_n,
   input  logic                  wr_n,
   input  logic                  rfsh_n,
   output logic [Z80_DATA_W-1:0] di,
   output logic                  wait_n,
   input  logic                  dbg_we,
   input  logic                  dbg_io,
   input  logic [Z80_ADDR_W-1:0] dbg_addr,
   input  logic [Z80_DATA_W-1:0] dbg_wdata,
   output logic [Z80_DATA_W-1:0] dbg_rdata,
   output logic                  dbg_collide,
   output logic [15:0]           wr_count,
   output logic [Z80_ADDR_W-1:0] last_wr_addr,
   output logic [Z80_DATA_W-1:0] last_wr_data,
   output logic                  last_wr_io
);
   bus_state_t            state;
   logic [3:0]            waitcnt, req_wait;
   logic                  sp_io, wr_done, di_vec, di_io, dbg_sel_io;
   logic                  mem_req, io_req, req, cur_io, ack, rd_active;
   logic                  cpu_wr, cpu_we_mem, cpu_we_io, dbg_we_mem, dbg_we_io;
   logic                  mem_coll, io_coll, mem_we, io_we;
   logic [ADDR_W-1:0]     mem_waddr;
   logic [IO_ADDR_W-1:0]  io_waddr;
   logic [Z80_DATA_W-1:0] mem_wdata, io_wdata, mem_qa, mem_qb, io_qa, io_qb;
   logic                  unused_rd_n;

   assign unused_rd_n = rd_n;

   assign mem_req   = !mreq_n && rfsh_n;
   assign io_req    = !iorq_n;
   assign req       = mem_req || io_req;
   assign req_wait  = io_req ? 4'(IO_WAIT) : 4'(MEM_WAIT);
   assign cur_io    = (state == IDLE) ? io_req : sp_io;
   assign ack       = cur_io && !m1_n;
   assign rd_active = ((state == IDLE) && req) || (state == WAIT) || (state == ACCESS);

   // Reset abandons a write that would otherwise land on the reset edge.
   assign cpu_wr     = reset_n && (state == ACCESS) && !wr_n && !wr_done;
   assign cpu_we_mem = cpu_wr && !sp_io;
   assign cpu_we_io  = cpu_wr && sp_io && m1_n;
   assign dbg_we_mem = dbg_we && !dbg_io;
   assign dbg_we_io  = dbg_we && dbg_io;

   // One write port per array: the CPU owns it whenever it writes that space,
   // so a backdoor write into the same space that cycle is dropped.
   assign mem_coll  = dbg_we_mem && cpu_we_mem;
   assign io_coll   = dbg_we_io && cpu_we_io;
   assign mem_we    = cpu_we_mem || dbg_we_mem;
   assign io_we     = cpu_we_io || dbg_we_io;
   assign mem_waddr = cpu_we_mem ? A[ADDR_W-1:0] : dbg_addr[ADDR_W-1:0];
   assign io_waddr  = cpu_we_io ? A[IO_ADDR_W-1:0] : dbg_addr[IO_ADDR_W-1:0];
   assign mem_wdata = cpu_we_mem ? dout : dbg_wdata;
   assign io_wdata  = cpu_we_io ? dout : dbg_wdata;

   assign di        = di_vec ? IM2_VECTOR : (di_io ? io_qa : mem_qa);
   assign dbg_rdata = dbg_sel_io ? io_qb : mem_qb;

   z80_sp_ram #(.AW(ADDR_W)) u_mem (
      .clk(clk), .reset_n(reset_n),
      .we(mem_we), .waddr(mem_waddr), .wdata(mem_wdata),
      .re_a(rd_active && !cur_io), .raddr_a(A[ADDR_W-1:0]), .rdata_a(mem_qa),
      .raddr_b(dbg_addr[ADDR_W-1:0]), .rdata_b(mem_qb)
   );

   z80_sp_ram #(.AW(IO_ADDR_W)) u_io (
      .clk(clk), .reset_n(reset_n),
      .we(io_we), .waddr(io_waddr), .wdata(io_wdata),
      .re_a(rd_active && cur_io && !ack), .raddr_a(A[IO_ADDR_W-1:0]), .rdata_a(io_qa),
      .raddr_b(dbg_addr[IO_ADDR_W-1:0]), .rdata_b(io_qb)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         wait_n       <= 1'b1;
         waitcnt      <= '0;
         sp_io        <= 1'b0;
         wr_done      <= 1'b0;
         di_vec       <= 1'b0;
         di_io        <= 1'b0;
         dbg_sel_io   <= 1'b0;
         dbg_collide  <= 1'b0;
         wr_count     <= '0;
         last_wr_addr <= '0;
         last_wr_data <= '0;
         last_wr_io   <= 1'b0;
      end else begin
         dbg_sel_io  <= dbg_io;
         dbg_collide <= mem_coll || io_coll;
         if (rd_active) begin
            di_vec <= ack;
            di_io  <= cur_io;
         end
         if (cpu_we_mem || cpu_we_io) begin
            wr_count     <= (wr_count == 16'hFFFF) ? wr_count : 16'(wr_count + 16'd1);
            last_wr_addr <= A;
            last_wr_data <= dout;
            last_wr_io   <= sp_io;
         end
         case (state)
            IDLE: begin
               wr_done <= 1'b0;
               if (req) begin
                  sp_io <= io_req;
                  if (req_wait != 4'd0) begin
                     state   <= WAIT;
                     waitcnt <= req_wait - 4'd1;
                     wait_n  <= 1'b0;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            WAIT: begin
               if (waitcnt == 4'd0) begin
                  state  <= ACCESS;
                  wait_n <= 1'b1;
               end else begin
                  waitcnt <= waitcnt - 4'd1;
               end
            end
            ACCESS: begin
               if (cpu_wr)
                  wr_done <= 1'b1;
               if (mreq_n && iorq_n)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_z80_bus_mem.sv
// Bench for z80_bus_mem: two parameterisations share one stimulus stream and
// are compared against an array-based model of memory, I/O and write trace.
module tb_z80_bus_mem;
   localparam int         A_MEM_WAIT = 0, A_IO_WAIT = 1;
   localparam int         B_MEM_WAIT = 2, B_IO_WAIT = 3;
   localparam logic [7:0] A_VEC = 8'hFF, B_VEC = 8'hA5;
   localparam int         HOLD = 6;

   logic        clk = 1'b0;
   logic        reset_n, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, dbg_we, dbg_io;
   logic [15:0] A, dbg_addr;
   logic [7:0]  dout, dbg_wdata;

   logic [7:0]  di_a, di_b, dbg_rdata_a, dbg_rdata_b, last_wr_data_a, last_wr_data_b;
   logic        wait_n_a, wait_n_b, dbg_collide_a, dbg_collide_b, last_wr_io_a, last_wr_io_b;
   logic [15:0] wr_count_a, wr_count_b, last_wr_addr_a, last_wr_addr_b;

   logic [7:0]  mem_a [65536];
   logic [7:0]  mem_b [4096];
   logic [7:0]  io_a  [256];
   logic [7:0]  io_b  [16];
   logic [15:0] model_cnt, model_last_addr;
   logic [7:0]  model_last_data;
   logic        model_last_io;
   logic [15:0] mem_list [$];
   logic [15:0] io_list  [$];

   int n_compared = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   z80_bus_mem #(.ADDR_W(16), .IO_ADDR_W(8), .MEM_WAIT(A_MEM_WAIT), .IO_WAIT(A_IO_WAIT),
                 .IM2_VECTOR(A_VEC)) dut_a (
      .clk(clk), .reset_n(reset_n), .A(A), .dout(dout), .m1_n(m1_n), .mreq_n(mreq_n),
      .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .di(di_a), .wait_n(wait_n_a),
      .dbg_we(dbg_we), .dbg_io(dbg_io), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata_a), .dbg_collide(dbg_collide_a), .wr_count(wr_count_a),
      .last_wr_addr(last_wr_addr_a), .last_wr_data(last_wr_data_a), .last_wr_io(last_wr_io_a)
   );

   z80_bus_mem #(.ADDR_W(12), .IO_ADDR_W(4), .MEM_WAIT(B_MEM_WAIT), .IO_WAIT(B_IO_WAIT),
                 .IM2_VECTOR(B_VEC)) dut_b (
      .clk(clk), .reset_n(reset_n), .A(A), .dout(dout), .m1_n(m1_n), .mreq_n(mreq_n),
      .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .di(di_b), .wait_n(wait_n_b),
      .dbg_we(dbg_we), .dbg_io(dbg_io), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata_b), .dbg_collide(dbg_collide_b), .wr_count(wr_count_b),
      .last_wr_addr(last_wr_addr_b), .last_wr_data(last_wr_data_b), .last_wr_io(last_wr_io_b)
   );

   initial begin
      #2_000_000;
      $fatal(1, "[TB] FAIL watchdog: simulation time limit expired");
   end

   function automatic logic [7:0] modelRead(input bit dut_b, input bit io, input logic [15:0] addr);
      if (io)
         return dut_b ? io_b[addr[3:0]] : io_a[addr[7:0]];
      return dut_b ? mem_b[addr[11:0]] : mem_a[addr];
   endfunction

   task automatic modelWrite(input bit dut_b, input bit io, input logic [15:0] addr, input logic [7:0] data);
      if (io) begin
         if (dut_b) io_b[addr[3:0]] = data;
         else       io_a[addr[7:0]] = data;
      end else begin
         if (dut_b) mem_b[addr[11:0]] = data;
         else       mem_a[addr] = data;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleBus();
      m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
      dbg_we = 1'b0;
   endtask

   task automatic checkTrace();
      checkOutput("wr_count_a", wr_count_a, model_cnt);
      checkOutput("wr_count_b", wr_count_b, model_cnt);
      checkOutput("last_wr_addr_a", last_wr_addr_a, model_last_addr);
      checkOutput("last_wr_addr_b", last_wr_addr_b, model_last_addr);
      checkOutput("last_wr_data_a", last_wr_data_a, model_last_data);
      checkOutput("last_wr_data_b", last_wr_data_b, model_last_data);
      checkOutput("last_wr_io_a", last_wr_io_a, model_last_io);
      checkOutput("last_wr_io_b", last_wr_io_b, model_last_io);
   endtask

   task automatic pokeMem(input bit io, input logic [15:0] addr, input logic [7:0] data);
      dbg_we = 1'b1; dbg_io = io; dbg_addr = addr; dbg_wdata = data;
      tick();
      dbg_we = 1'b0;
      modelWrite(1'b0, io, addr, data);
      modelWrite(1'b1, io, addr, data);
      if (io) io_list.push_back(addr); else mem_list.push_back(addr);
      checkOutput("poke_collide_a", dbg_collide_a, 1'b0);
      checkOutput("poke_collide_b", dbg_collide_b, 1'b0);
   endtask

   task automatic peekCheck(input bit io, input logic [15:0] addr);
      dbg_we = 1'b0; dbg_io = io; dbg_addr = addr;
      tick();
      checkOutput("peek_a", dbg_rdata_a, modelRead(1'b0, io, addr));
      checkOutput("peek_b", dbg_rdata_b, modelRead(1'b1, io, addr));
   endtask

   // One complete CPU bus cycle; the model decides wait timing, write edge and collisions.
   task automatic applyStimulus(input bit io, input bit wr, input bit ack, input logic [15:0] addr,
                                input logic [7:0] data, input int dbg_edge, input logic [7:0] dbg_data);
      int         n_a, n_b;
      bit         cpu_a, cpu_b, writes;
      logic [7:0] rd_a, rd_b;
      n_a    = io ? A_IO_WAIT : A_MEM_WAIT;
      n_b    = io ? B_IO_WAIT : B_MEM_WAIT;
      writes = wr && !ack;
      rd_a   = ack ? A_VEC : modelRead(1'b0, io, addr);
      rd_b   = ack ? B_VEC : modelRead(1'b1, io, addr);
      A = addr; dout = data; m1_n = !ack; mreq_n = io; iorq_n = !io;
      rd_n = wr; wr_n = !wr; rfsh_n = 1'b1;
      for (int k = 1; k <= HOLD; k++) begin
         if (k == dbg_edge) begin
            dbg_we = 1'b1; dbg_io = io; dbg_addr = addr; dbg_wdata = dbg_data;
         end
         tick();
         dbg_we = 1'b0;
         cpu_a = writes && (k == n_a + 2);
         cpu_b = writes && (k == n_b + 2);
         if (k == dbg_edge && !cpu_a) modelWrite(1'b0, io, addr, dbg_data);
         if (k == dbg_edge && !cpu_b) modelWrite(1'b1, io, addr, dbg_data);
         if (cpu_a) modelWrite(1'b0, io, addr, data);
         if (cpu_b) modelWrite(1'b1, io, addr, data);
         checkOutput("wait_n_a", wait_n_a, (k <= n_a) ? 1'b0 : 1'b1);
         checkOutput("wait_n_b", wait_n_b, (k <= n_b) ? 1'b0 : 1'b1);
         checkOutput("collide_a", dbg_collide_a, (k == dbg_edge) && cpu_a);
         checkOutput("collide_b", dbg_collide_b, (k == dbg_edge) && cpu_b);
         if (!wr) begin
            checkOutput("di_a", di_a, rd_a);
            checkOutput("di_b", di_b, rd_b);
         end
      end
      idleBus();
      tick();
      tick();
      if (writes) begin
         model_cnt       = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1;
         model_last_addr = addr;
         model_last_data = data;
         model_last_io   = io;
         if (io) io_list.push_back(addr); else mem_list.push_back(addr);
      end
      checkTrace();
   endtask

   initial begin
      logic [15:0] addr;
      int          op;
      reset_n = 1'b0; A = '0; dout = '0; dbg_addr = '0; dbg_wdata = '0; dbg_io = 1'b0;
      idleBus();
      model_cnt = '0; model_last_addr = '0; model_last_data = '0; model_last_io = 1'b0;

      tick();
      tick();
      checkOutput("rst_wait_n_a", wait_n_a, 1'b1);
      checkOutput("rst_wait_n_b", wait_n_b, 1'b1);
      checkOutput("rst_di_a", di_a, 8'h00);
      checkOutput("rst_di_b", di_b, 8'h00);
      checkOutput("rst_dbg_rdata_a", dbg_rdata_a, 8'h00);
      checkOutput("rst_dbg_rdata_b", dbg_rdata_b, 8'h00);
      checkOutput("rst_collide_a", dbg_collide_a, 1'b0);
      checkOutput("rst_collide_b", dbg_collide_b, 1'b0);
      checkTrace();
      reset_n = 1'b1;
      tick();

      $display("[TB] preload and read C9F7");
      pokeMem(1'b0, 16'hC9F7, 8'h41);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'hC9F7, 8'h00, 0, 8'h00);

      $display("[TB] memory write C9F7 with wr_n held");
      applyStimulus(1'b0, 1'b1, 1'b0, 16'hC9F7, 8'h49, 0, 8'h00);
      peekCheck(1'b0, 16'hC9F7);

      $display("[TB] reset during wait states");
      A = 16'hC9F7; dout = 8'h77; mreq_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0;
      tick();
      checkOutput("midrst_wait_n_b_low", wait_n_b, 1'b0);
      reset_n = 1'b0;
      tick();
      model_cnt = '0; model_last_addr = '0; model_last_data = '0; model_last_io = 1'b0;
      checkOutput("midrst_wait_n_a", wait_n_a, 1'b1);
      checkOutput("midrst_wait_n_b", wait_n_b, 1'b1);
      checkOutput("midrst_di_a", di_a, 8'h00);
      checkTrace();
      idleBus();
      reset_n = 1'b1;
      tick();
      tick();
      peekCheck(1'b0, 16'hC9F7);

      $display("[TB] refresh cycle ignored");
      A = 16'h0042; mreq_n = 1'b0; rfsh_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput("rfsh_wait_n_a", wait_n_a, 1'b1);
         checkOutput("rfsh_wait_n_b", wait_n_b, 1'b1);
      end
      idleBus();
      tick();
      checkTrace();

      $display("[TB] I/O write and interrupt acknowledge");
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h001F, 8'h5A, 0, 8'h00);
      peekCheck(1'b1, 16'h001F);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0038, 8'h00, 0, 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h001F, 8'h99, 0, 8'h00);
      peekCheck(1'b1, 16'h001F);

      $display("[TB] address aliasing");
      pokeMem(1'b0, 16'h0234, 8'h11);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234, 8'hC3, 0, 8'h00);
      peekCheck(1'b0, 16'h0234);
      peekCheck(1'b0, 16'h1234);

      $display("[TB] backdoor write colliding with CPU write");
      applyStimulus(1'b0, 1'b1, 1'b0, 16'hC9F7, 8'hE1, 2, 8'h5E);
      peekCheck(1'b0, 16'hC9F7);

      $display("[TB] randomized bus traffic");
      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(6));
         case (op)
            0: begin
               addr = $urandom_range(1) ? 16'($urandom)
                                        : (mem_list[$urandom_range(mem_list.size() - 1)] ^ 16'hF000);
               applyStimulus(1'b0, 1'b1, 1'b0, addr, 8'($urandom), 0, 8'h00);
            end
            1: applyStimulus(1'b0, 1'b0, 1'b0, mem_list[$urandom_range(mem_list.size() - 1)],
                             8'h00, 0, 8'h00);
            2: applyStimulus(1'b1, 1'b1, 1'b0, 16'($urandom), 8'($urandom), 0, 8'h00);
            3: applyStimulus(1'b1, 1'b0, 1'b0, io_list[$urandom_range(io_list.size() - 1)],
                             8'h00, 0, 8'h00);
            4: applyStimulus(1'b1, 1'($urandom_range(1)), 1'b1, 16'($urandom), 8'($urandom), 0, 8'h00);
            5: pokeMem(1'($urandom_range(1)), 16'($urandom), 8'($urandom));
            default: begin
               if ($urandom_range(1) != 0)
                  peekCheck(1'b0, mem_list[$urandom_range(mem_list.size() - 1)]);
               else
                  peekCheck(1'b1, io_list[$urandom_range(io_list.size() - 1)]);
            end
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
